accel_mem_split_bridge: RTL

// Parametrised, registered successor to the single-cycle accelerator-to-memory bridge. Accepts a packed

---
 rtl/accel_mem_split_bridge_if.sv | 38 +++
 rtl/accel_mem_split_bridge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/accel_mem_split_bridge_if.sv
// Bus bundle between the accelerator command port, the split bridge and the memory.
// The bridge takes the master view; the accelerator/memory side takes the slave view.
interface accel_mem_split_bridge_if #(
    parameter int unsigned MEM_DATA_W = 64,
    parameter int unsigned ADDR_W     = 31
);
    localparam int unsigned MEM_BYTES = MEM_DATA_W / 8;

    logic [2*MEM_DATA_W-1:0] writedata_from_accel;
    logic                    address_from_accel;
    logic                    write_from_accel;
    logic                    read_from_accel;
    logic [2*MEM_DATA_W-1:0] readdata_to_accel;
    logic                    waitrequest_to_accel;

    logic [ADDR_W-1:0]       address_to_mem;
    logic                    read_to_mem;
    logic                    write_to_mem;
    logic [MEM_DATA_W-1:0]   writedata_to_mem;
    logic [MEM_BYTES-1:0]    byteenable_to_mem;
    logic                    waitrequest_from_mem;
    logic [MEM_DATA_W-1:0]   readdata_from_mem;
    logic                    readdatavalid_from_mem;

    modport master (
        input  writedata_from_accel, address_from_accel, write_from_accel, read_from_accel,
        output readdata_to_accel, waitrequest_to_accel,
        output address_to_mem, read_to_mem, write_to_mem, writedata_to_mem, byteenable_to_mem,
        input  waitrequest_from_mem, readdata_from_mem, readdatavalid_from_mem
    );

    modport slave (
        output writedata_from_accel, address_from_accel, write_from_accel, read_from_accel,
        input  readdata_to_accel, waitrequest_to_accel,
        input  address_to_mem, read_to_mem, write_to_mem, writedata_to_mem, byteenable_to_mem,
        output waitrequest_from_mem, readdata_from_mem, readdatavalid_from_mem
    );
endinterface

// File: rtl/accel_mem_split_bridge.sv
// Registered accelerator-to-memory bridge: splits word-crossing accesses into two aligned
// beats, and realigns/size-masks read data back to the accelerator.
module accel_mem_split_bridge #(
    parameter int unsigned MEM_DATA_W = 64,
    parameter int unsigned ADDR_W     = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    accel_mem_split_bridge_if.master bus
);
    localparam int unsigned MEM_BYTES = MEM_DATA_W / 8;
    localparam int unsigned OFF_W     = $clog2(MEM_BYTES);
    localparam int unsigned NB_W      = OFF_W + 1;
    localparam int unsigned CMD_W     = 2 * MEM_DATA_W;
    localparam int unsigned LANES2    = 2 * MEM_BYTES;
    localparam int unsigned DATA_LSB  = 32;
    localparam int unsigned SIZE_LSB  = MEM_DATA_W + 32;

    typedef enum logic [2:0] {IDLE, LO, LO_WAIT, HI, HI_WAIT, DONE} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]     cmd_addr;
    logic [ADDR_W-1:0]     cmd_base;
    logic [MEM_DATA_W-1:0] cmd_data;
    logic [MEM_DATA_W-1:0] cmd_data_keep;
    logic [2:0]            cmd_size;
    logic [2:0]            cmd_sz;
    logic [OFF_W-1:0]      cmd_off;
    logic [NB_W-1:0]       cmd_nbytes;
    logic [MEM_BYTES-1:0]  cmd_keep;
    logic [LANES2-1:0]     cmd_mask2;
    logic [CMD_W-1:0]      cmd_data2;
    logic                  cmd_split;
    logic                  capture;

    logic                  is_write_q;
    logic                  split_q;
    logic [OFF_W-1:0]      off_q;
    logic [MEM_BYTES-1:0]  keep_q;
    logic [LANES2-1:0]     mask2_q;
    logic [CMD_W-1:0]      data2_q;
    logic [ADDR_W-1:0]     base_q;
    logic [MEM_DATA_W-1:0] lo_word_q;

    logic                  waitreq_q, waitreq_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [MEM_DATA_W-1:0] wd_q, wd_d;
    logic [MEM_BYTES-1:0]  be_q, be_d;
    logic [CMD_W-1:0]      rdata_q, rdata_d;

    logic unused_cmd;
    assign unused_cmd = ^{bus.address_from_accel, bus.writedata_from_accel};

    // Field extraction, size clamp and two-word lane/data placement of the incoming command.
    always_comb begin : decode
        cmd_addr      = bus.writedata_from_accel[ADDR_W-1:0];
        cmd_data      = bus.writedata_from_accel[DATA_LSB +: MEM_DATA_W];
        cmd_size      = bus.writedata_from_accel[SIZE_LSB +: 3];
        cmd_off       = cmd_addr[OFF_W-1:0];
        cmd_base      = {cmd_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        cmd_sz        = (cmd_size > 3'(OFF_W)) ? 3'(OFF_W) : cmd_size;
        cmd_nbytes    = NB_W'(1) << cmd_sz;
        cmd_split     = (32'(cmd_off) + 32'(cmd_nbytes)) > MEM_BYTES;
        cmd_keep      = '0;
        cmd_data_keep = '0;
        for (int unsigned i = 0; i < MEM_BYTES; i++) begin
            if (i < 32'(cmd_nbytes)) begin
                cmd_keep[i]            = 1'b1;
                cmd_data_keep[i*8 +: 8] = cmd_data[i*8 +: 8];
            end
        end
        cmd_mask2 = LANES2'(cmd_keep) << cmd_off;
        cmd_data2 = CMD_W'(cmd_data_keep) << {cmd_off, 3'b000};
    end

    assign capture = (state_q == IDLE) && (bus.write_from_accel || bus.read_from_accel);

    always_ff @(posedge clk) begin : cmd_latch
        if (reset) begin
            is_write_q <= 1'b0;
            split_q    <= 1'b0;
            off_q      <= '0;
            keep_q     <= '0;
            mask2_q    <= '0;
            data2_q    <= '0;
            base_q     <= '0;
        end else if (capture) begin
            is_write_q <= bus.write_from_accel;
            split_q    <= cmd_split;
            off_q      <= cmd_off;
            keep_q     <= cmd_keep;
            mask2_q    <= cmd_mask2;
            data2_q    <= cmd_data2;
            base_q     <= cmd_base;
        end
    end

    always_ff @(posedge clk) begin : lo_word_latch
        if (reset) begin
            lo_word_q <= '0;
        end else if (state_q == LO_WAIT && bus.readdatavalid_from_mem) begin
            lo_word_q <= bus.readdata_from_mem;
        end
    end

    function automatic logic [CMD_W-1:0] realign(input logic [CMD_W-1:0]     words,
                                                 input logic [OFF_W-1:0]     off,
                                                 input logic [MEM_BYTES-1:0] keep);
        logic [CMD_W-1:0] shifted;
        logic [CMD_W-1:0] bitmask;
        shifted = words >> {off, 3'b000};
        bitmask = '0;
        for (int unsigned i = 0; i < MEM_BYTES; i++) begin
            bitmask[i*8 +: 8] = {8{keep[i]}};
        end
        return shifted & bitmask;
    endfunction

    always_ff @(posedge clk) begin : fsm_state
        if (reset) begin
            state_q   <= IDLE;
            waitreq_q <= 1'b1;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            waitreq_q <= waitreq_d;
            read_q    <= read_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
        end
    end

    // Back-to-back write beats keep the strobe high; reads wait for each response.
    always_comb begin : fsm_next
        state_d   = state_q;
        waitreq_d = 1'b1;
        read_d    = read_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = LO;
                    write_d = bus.write_from_accel;
                    read_d  = !bus.write_from_accel;
                    addr_d  = cmd_base;
                    be_d    = cmd_mask2[MEM_BYTES-1:0];
                    wd_d    = cmd_data2[MEM_DATA_W-1:0];
                end
            end
            LO: begin
                if (!bus.waitrequest_from_mem) begin
                    if (is_write_q && split_q) begin
                        state_d = HI;
                        addr_d  = base_q + ADDR_W'(MEM_BYTES);
                        be_d    = mask2_q[LANES2-1:MEM_BYTES];
                        wd_d    = data2_q[CMD_W-1:MEM_DATA_W];
                    end else if (is_write_q) begin
                        state_d   = DONE;
                        write_d   = 1'b0;
                        waitreq_d = 1'b0;
                    end else begin
                        state_d = LO_WAIT;
                        read_d  = 1'b0;
                    end
                end
            end
            LO_WAIT: begin
                if (bus.readdatavalid_from_mem) begin
                    if (split_q) begin
                        state_d = HI;
                        read_d  = 1'b1;
                        addr_d  = base_q + ADDR_W'(MEM_BYTES);
                        be_d    = mask2_q[LANES2-1:MEM_BYTES];
                        wd_d    = data2_q[CMD_W-1:MEM_DATA_W];
                    end else begin
                        state_d   = DONE;
                        waitreq_d = 1'b0;
                        rdata_d   = realign({MEM_DATA_W'(0), bus.readdata_from_mem}, off_q, keep_q);
                    end
                end
            end
            HI: begin
                if (!bus.waitrequest_from_mem) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (is_write_q) begin
                        state_d   = DONE;
                        waitreq_d = 1'b0;
                    end else begin
                        state_d = HI_WAIT;
                    end
                end
            end
            HI_WAIT: begin
                if (bus.readdatavalid_from_mem) begin
                    state_d   = DONE;
                    waitreq_d = 1'b0;
                    rdata_d   = realign({bus.readdata_from_mem, lo_word_q}, off_q, keep_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.waitrequest_to_accel = waitreq_q;
    assign bus.readdata_to_accel    = rdata_q;
    assign bus.read_to_mem          = read_q;
    assign bus.write_to_mem         = write_q;
    assign bus.address_to_mem       = addr_q;
    assign bus.writedata_to_mem     = wd_q;
    assign bus.byteenable_to_mem    = be_q;
endmodule
